// File: rtl/pc_gen_if.sv
// Fetch-side bus of the program-counter generator: next-PC controls in,
// fetch PC and return-address-stack status out.
interface pc_gen_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  logic                           Stall;
  logic                           Trap;
  logic                           Redirect;
  logic [WIDTH-1:0]               Redirect_Target;
  logic                           Push;
  logic [WIDTH-1:0]               Push_Addr;
  logic                           Pop;
  logic [WIDTH-1:0]               D_Out;
  logic [WIDTH-1:0]               Ras_Top;
  logic [$clog2(RAS_DEPTH+1)-1:0] Ras_Count;
  logic                           Ras_Overflow;
  logic                           Ras_Underflow;

  modport master (
    output Stall, Trap, Redirect, Redirect_Target, Push, Push_Addr, Pop,
    input  D_Out, Ras_Top, Ras_Count, Ras_Overflow, Ras_Underflow
  );

  modport slave (
    input  Stall, Trap, Redirect, Redirect_Target, Push, Push_Addr, Pop,
    output D_Out, Ras_Top, Ras_Count, Ras_Overflow, Ras_Underflow
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > stall > RAS pop > sequential step,
// with a circular return-address stack that overwrites its oldest entry when full.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080),
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic    Clk,
  input  logic    Rst,
  pc_gen_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_p1;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             ovf_p1;
  logic             unf_p1;

  logic [WIDTH-1:0] pc_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic             empty;
  logic             full;
  logic             advance;
  logic             do_push;
  logic             do_pop;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(RAS_DEPTH)) return c;
    return c + CNT_W'(1);
  endfunction

  assign top_idx = ptr_p1 - PTR_W'(1);
  assign empty   = (cnt_p1 == '0);
  assign full    = (cnt_p1 == CNT_W'(RAS_DEPTH));
  assign ras_top = empty ? '0 : ras_mem[top_idx];

  // Stack operations are suppressed whenever the fetch stream is flushed or frozen.
  assign advance = !bus.Trap && !bus.Redirect && !bus.Stall;
  assign do_push = advance && bus.Push;
  assign do_pop  = advance && bus.Pop;

  always_comb begin
    pc_nxt  = pc_p1 + WIDTH'(STEP);
    ptr_nxt = ptr_p1;
    cnt_nxt = cnt_p1;
    ovf_nxt = ovf_p1;
    unf_nxt = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_p1;

    if (bus.Trap)                pc_nxt = TRAP_VECTOR;
    else if (bus.Redirect)       pc_nxt = bus.Redirect_Target;
    else if (bus.Stall)          pc_nxt = pc_p1;
    else if (bus.Pop && !empty)  pc_nxt = ras_top;

    if (do_push && do_pop) begin
      wr_en = 1'b1;
      if (!empty) begin
        wr_idx = top_idx;
      end else begin
        ptr_nxt = ptr_p1 + PTR_W'(1);
        cnt_nxt = CNT_W'(1);
        unf_nxt = 1'b1;
      end
    end else if (do_push) begin
      // When full, the pointer already sits on the oldest entry.
      wr_en   = 1'b1;
      ptr_nxt = ptr_p1 + PTR_W'(1);
      cnt_nxt = cnt_sat_inc(cnt_p1);
      if (full) ovf_nxt = 1'b1;
    end else if (do_pop) begin
      if (!empty) begin
        ptr_nxt = top_idx;
        cnt_nxt = cnt_p1 - CNT_W'(1);
      end else begin
        unf_nxt = 1'b1;
      end
    end
  end

  // Stage p1: registered fetch PC and stack state
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_p1  <= RESET_VECTOR;
      ptr_p1 <= '0;
      cnt_p1 <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      pc_p1  <= pc_nxt;
      ptr_p1 <= ptr_nxt;
      cnt_p1 <= cnt_nxt;
      ovf_p1 <= ovf_nxt;
      unf_p1 <= unf_nxt;
      if (wr_en) ras_mem[wr_idx] <= bus.Push_Addr;
    end
  end

  assign bus.D_Out         = pc_p1;
  assign bus.Ras_Top       = ras_top;
  assign bus.Ras_Count     = cnt_p1;
  assign bus.Ras_Overflow  = ovf_p1;
  assign bus.Ras_Underflow = unf_p1;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: queue-based reference model checked every cycle, plus
// directed call/return, overflow, stall and async-reset scenarios with literal expectations.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pc_gen_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();
  pc_gen_if #(.WIDTH(8),  .RAS_DEPTH(4)) bus8 ();

  pc_gen #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .Clk(clk), .Rst(rst), .bus(bus)
  );

  pc_gen #(
    .WIDTH(8), .RESET_VECTOR(8'hFC), .TRAP_VECTOR(8'h80), .STEP(4), .RAS_DEPTH(4)
  ) dut8 (
    .Clk(clk), .Rst(rst), .bus(bus8)
  );

  always #5 clk = ~clk;

  // Reference model: PC as a plain number, the stack as a bounded queue (back = top).
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_ovf;
  bit          m_unf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc  = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      logic [31:0] nxt;
      bit adv, pp, po;
      adv = !bus.Trap && !bus.Redirect && !bus.Stall;
      pp  = adv && bus.Push;
      po  = adv && bus.Pop;
      nxt = m_pc + 32'd4;
      if (bus.Trap)                       nxt = 32'h80;
      else if (bus.Redirect)              nxt = bus.Redirect_Target;
      else if (bus.Stall)                 nxt = m_pc;
      else if (bus.Pop && m_q.size() > 0) nxt = m_q[m_q.size()-1];
      m_unf = 1'b0;
      if (pp && po) begin
        if (m_q.size() > 0) m_q[m_q.size()-1] = bus.Push_Addr;
        else begin m_q.push_back(bus.Push_Addr); m_unf = 1'b1; end
      end else if (pp) begin
        if (m_q.size() == 4) begin void'(m_q.pop_front()); m_ovf = 1'b1; end
        m_q.push_back(bus.Push_Addr);
      end else if (po) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_unf = 1'b1;
      end
      m_pc = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_d_out", bus.D_Out, m_pc);
      chk("model_ras_count", 32'(bus.Ras_Count), 32'(m_q.size()));
      chk("model_ras_top", bus.Ras_Top, (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0);
      chk("model_overflow", 32'(bus.Ras_Overflow), 32'(m_ovf));
      chk("model_underflow", 32'(bus.Ras_Underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic st, input logic tr, input logic rd, input logic [31:0] tgt,
                     input logic pu, input logic [31:0] pa, input logic po);
    bus.Stall = st; bus.Trap = tr; bus.Redirect = rd; bus.Redirect_Target = tgt;
    bus.Push = pu; bus.Push_Addr = pa; bus.Pop = po;
    @(negedge clk);
  endtask

  task automatic idle();  cyc(0, 0, 0, 32'h0, 0, 32'h0, 0); endtask
  task automatic push(input logic [31:0] a); cyc(0, 0, 0, 32'h0, 1, a, 0); endtask
  task automatic pop();   cyc(0, 0, 0, 32'h0, 0, 32'h0, 1); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Stall = 0; bus.Trap = 0; bus.Redirect = 0; bus.Redirect_Target = '0;
    bus.Push = 0; bus.Push_Addr = '0; bus.Pop = 0;
    bus8.Stall = 0; bus8.Trap = 0; bus8.Redirect = 0; bus8.Redirect_Target = '0;
    bus8.Push = 0; bus8.Push_Addr = '0; bus8.Pop = 0;

    repeat (2) @(negedge clk);
    chk("reset_d_out", bus.D_Out, 32'h0);
    chk("reset_count", 32'(bus.Ras_Count), 32'h0);
    chk("reset_top", bus.Ras_Top, 32'h0);
    chk("reset_ovf", 32'(bus.Ras_Overflow), 32'h0);
    chk("reset_unf", 32'(bus.Ras_Underflow), 32'h0);
    chk("reset_d8", 32'(bus8.D_Out), 32'hFC);
    rst = 1'b0;
    chk_en = 1'b1;

    // Sequential stepping and 8-bit wrap
    idle(); chk("seq_4", bus.D_Out, 32'h4); chk("wrap_d8", 32'(bus8.D_Out), 32'h00);
    idle(); chk("seq_8", bus.D_Out, 32'h8);
    idle(); chk("seq_12", bus.D_Out, 32'hC);

    // Stall versus redirect/trap
    cyc(0, 0, 1, 32'h20, 0, 32'h0, 0); chk("redir_20", bus.D_Out, 32'h20);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 32'h0, 0, 32'h0, 0); chk("stall_hold", bus.D_Out, 32'h20);
    end
    cyc(1, 0, 1, 32'h400, 0, 32'h0, 0); chk("redir_in_stall", bus.D_Out, 32'h400);
    cyc(0, 1, 1, 32'h999, 0, 32'h0, 0); chk("trap_over_redir", bus.D_Out, 32'h80);

    // Call / return
    push(32'h104); chk("call1_pc", bus.D_Out, 32'h84); chk("call1_top", bus.Ras_Top, 32'h104);
    push(32'h208); chk("call2_cnt", 32'(bus.Ras_Count), 32'h2); chk("call2_top", bus.Ras_Top, 32'h208);
    pop(); chk("ret1_pc", bus.D_Out, 32'h208); chk("ret1_top", bus.Ras_Top, 32'h104);
    pop(); chk("ret2_pc", bus.D_Out, 32'h104); chk("ret2_cnt", 32'(bus.Ras_Count), 32'h0);

    // Overflow then drain, then underflow
    for (int i = 1; i <= 5; i++) push(32'(i * 16));
    chk("ovf_pc", bus.D_Out, 32'h118);
    chk("ovf_cnt", 32'(bus.Ras_Count), 32'h4);
    chk("ovf_flag", 32'(bus.Ras_Overflow), 32'h1);
    pop(); chk("drain_50", bus.D_Out, 32'h50);
    pop(); chk("drain_40", bus.D_Out, 32'h40);
    pop(); chk("drain_30", bus.D_Out, 32'h30);
    pop(); chk("drain_20", bus.D_Out, 32'h20);
    pop(); chk("unf_pc", bus.D_Out, 32'h24); chk("unf_pulse", 32'(bus.Ras_Underflow), 32'h1);
    idle(); chk("unf_clear", 32'(bus.Ras_Underflow), 32'h0); chk("ovf_sticky", 32'(bus.Ras_Overflow), 32'h1);

    // Simultaneous push+pop
    push(32'h300); chk("pp_setup_top", bus.Ras_Top, 32'h300);
    cyc(0, 0, 0, 32'h0, 1, 32'h500, 1);
    chk("pp_pc", bus.D_Out, 32'h300); chk("pp_top", bus.Ras_Top, 32'h500); chk("pp_cnt", 32'(bus.Ras_Count), 32'h1);
    cyc(1, 0, 0, 32'h0, 1, 32'h600, 1);
    chk("pp_stall_pc", bus.D_Out, 32'h300); chk("pp_stall_top", bus.Ras_Top, 32'h500);
    pop(); chk("pp_ret", bus.D_Out, 32'h500);
    cyc(0, 0, 0, 32'h0, 1, 32'h700, 1);
    chk("pp_empty_pc", bus.D_Out, 32'h504); chk("pp_empty_top", bus.Ras_Top, 32'h700);
    chk("pp_empty_unf", 32'(bus.Ras_Underflow), 32'h1);

    // Asynchronous reset with three entries and a push in flight
    push(32'h11); push(32'h22);
    chk("pre_rst_cnt", 32'(bus.Ras_Count), 32'h3);
    bus.Push = 1; bus.Push_Addr = 32'h33;
    #2 rst = 1'b1;
    #1;
    chk("async_d_out", bus.D_Out, 32'h0);
    chk("async_cnt", 32'(bus.Ras_Count), 32'h0);
    chk("async_ovf", 32'(bus.Ras_Overflow), 32'h0);
    chk("async_top", bus.Ras_Top, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(); chk("post_rst_pc", bus.D_Out, 32'h4); chk("post_rst_cnt", 32'(bus.Ras_Count), 32'h0);
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
